// File: rtl/fir_pkg.sv
// Shared types and elaboration-time helpers for the time-multiplexed FIR MAC filter.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } fir_state_e;

    // Full product width plus log2(ntaps) guard bits so the sum of all taps cannot overflow.
    function automatic int acc_width(input int data_w, input int coef_w, input int ntaps);
        return data_w + coef_w + $clog2(ntaps);
    endfunction

    function automatic logic [63:0] round_const(input int shift);
        return (shift > 0) ? (64'd1 << (shift - 1)) : 64'd0;
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational output stage: round half toward +inf, arithmetic shift by SHIFT, saturate to OUT_W.
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int ACC_W = 35,
    parameter int OUT_W = 16,
    parameter int SHIFT = 14
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [OUT_W-1:0] y
);

    // One extra bit so adding the rounding constant can never wrap.
    localparam int EXT_W = ACC_W + 1;
    localparam logic [63:0] RND = round_const(SHIFT);
    localparam logic signed [EXT_W-1:0] Y_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] Y_MIN = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [EXT_W-1:0] sum;
    logic signed [EXT_W-1:0] shifted;

    always_comb begin
        sum     = {acc[ACC_W-1], acc} + $signed(EXT_W'(RND));
        shifted = sum >>> SHIFT;
        if (shifted > Y_MAX) begin
            y = Y_MAX[OUT_W-1:0];
        end else if (shifted < Y_MIN) begin
            y = Y_MIN[OUT_W-1:0];
        end else begin
            y = shifted[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/fir_filter_mac.sv
// Time-multiplexed FIR: one MAC walks NTAPS programmable taps per accepted sample.
// Input handshake: a sample is taken on a rising edge where x_valid=1 and x_ready=1; y_valid is a one-cycle strobe.
module fir_filter_mac
    import fir_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int OUT_W  = 16,
    parameter int NTAPS  = 8,
    parameter int SHIFT  = 14
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       coef_we,
    input  logic [$clog2(NTAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]   coef_wdata,
    input  logic                       x_valid,
    output logic                       x_ready,
    input  logic signed [DATA_W-1:0]   x_in,
    output logic                       y_valid,
    output logic signed [OUT_W-1:0]    y_out
);

    localparam int ACC_W  = acc_width(DATA_W, COEF_W, NTAPS);
    localparam int IDX_W  = $clog2(NTAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NTAPS - 1);

    fir_state_e                 state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [DATA_W-1:0]   dly_q [NTAPS];
    logic signed [DATA_W-1:0]   dly_d [NTAPS];
    logic signed [COEF_W-1:0]   coef_q [NTAPS];
    logic signed [COEF_W-1:0]   coef_d [NTAPS];
    logic                       x_ready_q, x_ready_d;
    logic                       y_valid_q, y_valid_d;
    logic signed [OUT_W-1:0]    y_out_q, y_out_d;
    logic signed [PROD_W-1:0]   prod;
    logic signed [OUT_W-1:0]    y_rnd;

    fir_round_sat #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .acc (acc_q),
        .y   (y_rnd)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        dly_d     = dly_q;
        coef_d    = coef_q;
        x_ready_d = x_ready_q;
        y_valid_d = 1'b0;
        y_out_d   = y_out_q;
        prod      = dly_q[idx_q] * coef_q[idx_q];

        case (state_q)
            IDLE: begin
                // A coefficient written alongside a sample is already visible to that sample's pass.
                if (coef_we) begin
                    coef_d[coef_addr] = coef_wdata;
                end
                if (x_valid) begin
                    for (int i = NTAPS - 1; i > 0; i--) begin
                        dly_d[i] = dly_q[i-1];
                    end
                    dly_d[0]  = x_in;
                    acc_d     = '0;
                    idx_d     = '0;
                    x_ready_d = 1'b0;
                    state_d   = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                y_out_d   = y_rnd;
                y_valid_d = 1'b1;
                x_ready_d = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                x_ready_d = 1'b1;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            acc_q     <= '0;
            for (int i = 0; i < NTAPS; i++) begin
                dly_q[i]  <= '0;
                coef_q[i] <= '0;
            end
            coef_q[0] <= COEF_W'(1 << SHIFT);
            x_ready_q <= 1'b1;
            y_valid_q <= 1'b0;
            y_out_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            dly_q     <= dly_d;
            coef_q    <= coef_d;
            x_ready_q <= x_ready_d;
            y_valid_q <= y_valid_d;
            y_out_q   <= y_out_d;
        end
    end

    assign x_ready = x_ready_q;
    assign y_valid = y_valid_q;
    assign y_out   = y_out_q;

endmodule

// File: tb/tb_fir_filter_mac.sv
// Self-checking bench for fir_filter_mac: vector table, hand-written corner sequences, randomized model comparison.
module tb_fir_filter_mac;

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int OUT_W  = 16;
    localparam int NTAPS  = 8;
    localparam int SHIFT  = 14;
    localparam int IDX_W  = $clog2(NTAPS);

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      coef_we;
    logic [IDX_W-1:0]          coef_addr;
    logic signed [COEF_W-1:0]  coef_wdata;
    logic                      x_valid;
    logic                      x_ready;
    logic signed [DATA_W-1:0]  x_in;
    logic                      y_valid;
    logic signed [OUT_W-1:0]   y_out;

    fir_filter_mac #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .OUT_W  (OUT_W),
        .NTAPS  (NTAPS),
        .SHIFT  (SHIFT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .x_valid    (x_valid),
        .x_ready    (x_ready),
        .x_in       (x_in),
        .y_valid    (y_valid),
        .y_out      (y_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference model: a tap array and a sample history, evaluated directly as a dot product.
    int m_coef [NTAPS];
    int m_hist [NTAPS];
    logic [OUT_W-1:0] exp_q [$];

    task automatic model_reset();
        for (int i = 0; i < NTAPS; i++) begin
            m_coef[i] = 0;
            m_hist[i] = 0;
        end
        m_coef[0] = 1 << SHIFT;
    endtask

    task automatic model_write(input int a, input int v);
        m_coef[a] = v;
    endtask

    task automatic model_accept(input int x, output int y);
        longint acc;
        longint r;
        longint ymax;
        longint ymin;
        for (int i = NTAPS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = x;
        acc = 0;
        for (int i = 0; i < NTAPS; i++) acc += longint'(m_hist[i]) * longint'(m_coef[i]);
        r    = (acc + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT;
        ymax = (64'sd1 <<< (OUT_W - 1)) - 1;
        ymin = -ymax - 1;
        if (r > ymax) r = ymax;
        if (r < ymin) r = ymin;
        y = int'(r);
    endtask

    task automatic apply_reset();
        reset   = 1'b1;
        x_valid = 1'b0;
        coef_we = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic write_coef(input int a, input int v);
        coef_we    = 1'b1;
        coef_addr  = IDX_W'(a);
        coef_wdata = COEF_W'(v);
        @(negedge clk);
        coef_we = 1'b0;
        model_write(a, v);
    endtask

    // Offers one sample, optionally with a same-cycle coefficient write or a write while busy,
    // and returns the filtered result after checking handshake timing around it.
    task automatic do_sample(input int x, input bit wr_same, input int wr_addr, input int wr_data,
                             input int mac_wr_at, output int y);
        int n;
        bit busy_bad;
        n = 0;
        while (!x_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("x_ready_before_offer", int'(x_ready), 1);
        x_valid = 1'b1;
        x_in    = DATA_W'(x);
        if (wr_same) begin
            coef_we    = 1'b1;
            coef_addr  = IDX_W'(wr_addr);
            coef_wdata = COEF_W'(wr_data);
        end
        @(negedge clk);
        x_valid  = 1'b0;
        coef_we  = 1'b0;
        x_in     = DATA_W'($urandom);
        n        = 0;
        busy_bad = 1'b0;
        while (!y_valid && n < 40) begin
            if (x_ready) busy_bad = 1'b1;
            coef_we    = (n == mac_wr_at);
            coef_addr  = IDX_W'(wr_addr);
            coef_wdata = COEF_W'(wr_data);
            @(negedge clk);
            n++;
        end
        coef_we = 1'b0;
        check("latency_edges", n, NTAPS + 1);
        check("x_ready_low_while_busy", int'(busy_bad), 0);
        check("x_ready_after_result", int'(x_ready), 1);
        y = int'(y_out);
        @(negedge clk);
        check("y_valid_one_cycle", int'(y_valid), 0);
        check("y_out_held", int'(y_out), y);
    endtask

    typedef struct {
        bit do_rst;
        int coef_mode;
        int x;
        int exp_y;
    } vec_t;

    vec_t tbl [$];

    task automatic add_vec(input bit r, input int m, input int x, input int e);
        vec_t v;
        v.do_rst    = r;
        v.coef_mode = m;
        v.x         = x;
        v.exp_y     = e;
        tbl.push_back(v);
    endtask

    task automatic load_coefs(input int mode);
        for (int i = 0; i < NTAPS; i++) begin
            case (mode)
                1: write_coef(i, 2048);
                2: write_coef(i, (i + 1) * 1024);
                3: write_coef(i, 16383);
                default: ;
            endcase
        end
    endtask

    initial begin
        int y;
        int e;
        int n;
        bit seen;
        vec_t v;
        logic [OUT_W-1:0] ev;

        reset      = 1'b1;
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_wdata = '0;
        x_valid    = 1'b0;
        x_in       = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_y_out", int'(y_out), 0);
        check("reset_y_valid", int'(y_valid), 0);
        check("reset_x_ready", int'(x_ready), 1);

        // Unity passthrough, 1/8 running average, tap ramp impulse response, saturation, negative rounding.
        add_vec(1, 0, 100, 100);
        add_vec(0, 0, -100, -100);
        add_vec(1, 1, 100, 13);
        add_vec(0, 0, 100, 25);
        add_vec(0, 0, 100, 38);
        add_vec(0, 0, 100, 50);
        add_vec(0, 0, 100, 63);
        add_vec(0, 0, 100, 75);
        add_vec(0, 0, 100, 88);
        add_vec(0, 0, 100, 100);
        add_vec(1, 2, 500, 31);
        add_vec(0, 0, 0, 63);
        add_vec(0, 0, 0, 94);
        add_vec(0, 0, 0, 125);
        add_vec(0, 0, 0, 156);
        add_vec(0, 0, 0, 188);
        add_vec(0, 0, 0, 219);
        add_vec(0, 0, 0, 250);
        add_vec(0, 0, 0, 0);
        add_vec(1, 3, 32767, 32765);
        for (int i = 0; i < 7; i++) add_vec(0, 0, 32767, 32767);
        add_vec(1, 3, -32768, -32766);
        for (int i = 0; i < 7; i++) add_vec(0, 0, -32768, -32768);
        add_vec(1, 1, -100, -12);

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            if (v.do_rst) apply_reset();
            load_coefs(v.coef_mode);
            do_sample(v.x, 1'b0, 0, 0, -1, y);
            check($sformatf("vec%0d_y", i), y, v.exp_y);
        end

        // Coefficient write while busy is dropped; the same write in IDLE lands.
        apply_reset();
        do_sample(100, 1'b0, 1, 16384, 0, y);
        check("busy_write_current", y, 100);
        do_sample(100, 1'b0, 0, 0, -1, y);
        check("busy_write_next", y, 100);
        write_coef(1, 16384);
        do_sample(100, 1'b0, 0, 0, -1, y);
        check("idle_write_applied", y, 200);
        do_sample(100, 1'b1, 0, 2048, -1, y);
        check("same_cycle_write", y, 113);

        // x_valid held through a busy pass is taken only once x_ready returns.
        apply_reset();
        x_valid = 1'b1;
        x_in    = DATA_W'(100);
        @(negedge clk);
        x_in = DATA_W'(50);
        n = 0;
        while (!y_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("held_first_latency", n, NTAPS + 1);
        check("held_first_y", int'(y_out), 100);
        @(negedge clk);
        x_valid = 1'b0;
        n = 0;
        while (!y_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("held_second_latency", n, NTAPS + 1);
        check("held_second_y", int'(y_out), 50);
        @(negedge clk);

        // Reset three edges into a pass aborts it and clears the history.
        apply_reset();
        do_sample(1000, 1'b0, 0, 0, -1, y);
        do_sample(1000, 1'b0, 0, 0, -1, y);
        check("pre_abort_y", y, 1000);
        x_valid = 1'b1;
        x_in    = DATA_W'(100);
        @(negedge clk);
        x_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_x_ready", int'(x_ready), 1);
        check("abort_y_out", int'(y_out), 0);
        seen = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (y_valid) seen = 1'b1;
            @(negedge clk);
        end
        check("abort_no_y_valid", int'(seen), 0);
        do_sample(100, 1'b0, 0, 0, -1, y);
        check("post_abort_y", y, 100);
        load_coefs(1);
        do_sample(0, 1'b0, 0, 0, -1, y);
        check("post_abort_no_residue", y, 13);

        // Randomized coefficients and samples against the reference model.
        apply_reset();
        model_reset();
        for (int i = 0; i < NTAPS; i++) write_coef(i, int'($urandom_range(0, 65535)) - 32768);
        for (int i = 0; i < 40; i++) begin
            int x;
            int wa;
            int wd;
            int mac_at;
            bit same;
            x      = int'($urandom_range(0, 65535)) - 32768;
            same   = ($urandom_range(0, 3) == 0);
            wa     = int'($urandom_range(0, NTAPS - 1));
            wd     = int'($urandom_range(0, 65535)) - 32768;
            mac_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NTAPS - 1)) : -1;
            if (same) model_write(wa, wd);
            model_accept(x, e);
            exp_q.push_back(OUT_W'(e));
            do_sample(x, same, wa, wd, mac_at, y);
            if (exp_q.size() > 0) begin
                ev = exp_q.pop_front();
                check($sformatf("random%0d_y", i), y, int'($signed(ev)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_filter_mac.md
Name: fir_filter_mac

Overview:
Parametrised time-multiplexed FIR filter, the successor to the fixed 16-bit FIR_Filter.
- A single multiply-accumulate unit iterates over NTAPS runtime-programmable coefficients.
- Adds a valid/ready input handshake and a one-cycle output valid strobe.
- Output is rounded, scaled and saturated.
- Sits between the sample source and downstream DSP stages; a host or config logic loads coefficients through a simple write port.

Parameters:
- DATA_W, 16, signed input sample width.
- COEF_W, 16, signed coefficient width.
- OUT_W, 16, signed output width.
- NTAPS, 8, number of taps (>=2).
- SHIFT, 14, fractional bits of coefficients (Q format); output = acc >> SHIFT.
- ACC_W, DATA_W+COEF_W+$clog2(NTAPS), accumulator width (derived, not overridden).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  $clog2(NTAPS)  coefficient index.
- coef_wdata  in  COEF_W  signed coefficient value.
- x_valid  in  1  input sample valid.
- x_ready  out  1  block can accept a sample.
- x_in  in  DATA_W  signed input sample.
- y_valid  out  1  one-cycle pulse, y_out valid.
- y_out  out  OUT_W  signed filtered output, held until next result.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; delay line all 0; acc=0; tap index=0.
  - y_out=0, y_valid=0, x_ready=1.
  - coef[0]=1<<SHIFT (unity passthrough); all other coef=0.
- FSM states IDLE -> MAC -> DONE -> IDLE.
- IDLE:
  - x_ready=1.
  - On an edge with x_valid=1, shift the delay line (d[i]<=d[i-1], d[0]<=x_in), clear acc, set idx=0, go to MAC.
- MAC:
  - x_ready=0.
  - Each edge: acc += d[idx]*coef[idx] (full-precision signed product, sign-extended to ACC_W); idx++.
  - After the edge with idx==NTAPS-1, go to DONE. Exactly NTAPS MAC edges.
- DONE:
  - r = (acc + (1<<(SHIFT-1))) >>> SHIFT (round half toward +inf).
  - Saturate r to [-(2^(OUT_W-1)), 2^(OUT_W-1)-1].
  - Register into y_out; y_valid=1 for this one cycle; go to IDLE.
- Latency: sample accepted on edge k -> y_valid high after edge k+NTAPS+1 (NTAPS=8: 9 edges).
- Throughput: one sample per NTAPS+2 cycles.
- The output has no backpressure; the consumer must take y_out on the y_valid pulse.
- x_valid while x_ready=0: ignored. The source holds x_valid until it sees x_ready=1 on the same edge.
- Coefficient writes:
  - Applied only when state==IDLE.
  - coef_we in MAC/DONE is dropped silently.
  - A write and a sample acceptance in the same IDLE cycle are both applied; the new coef is used for that sample's MAC pass.
- Reset mid-MAC: the pass is aborted with no y_valid pulse; the delay line is cleared; x_ready=1 on the next cycle.
- Accumulator never overflows (ACC_W includes log2(NTAPS) guard bits). Saturation happens only at the output.

Decomposition:
- Package fir_pkg holds:
  - the FSM state enum (IDLE, MAC, DONE);
  - the ACC_W derivation function;
  - the rounding-constant helper.
- One sub-module, fir_round_sat: combinational acc -> rounded, shifted, saturated OUT_W value (parameters ACC_W, OUT_W, SHIFT). Verified standalone.

Test Plan:
- Reset, then x=100 with default coefs -> y_valid exactly 9 edges after acceptance, y_out=100; x=-100 -> y_out=-100; x_ready low for the 9 edges after acceptance.
- Write all coefs=2048 (1/8), then feed 8 consecutive x=100 -> y_out sequence 13,25,38,50,63,75,88,100.
- coef[i]=(i+1)*1024; impulse 500 followed by zeros -> y_out 31,63,94,125,156,188,219,250, then 0.
- Saturation: all coefs=16383, 8 samples of 32767 -> final y_out=32767; 8 samples of -32768 -> final y_out=-32768. Negative rounding: coefs=2048, single x=-100 -> y_out=-12.
- Write coef during MAC -> no effect on the current or next output; same write in IDLE takes effect. x_valid held while busy -> accepted only when x_ready returns.
- Assert reset 3 edges into a MAC pass -> no y_valid pulse, y_out=0. Next x=100 with default coefs -> y_out=100, with no residue from the old delay line.
